// File: rtl/mul_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// mul_pipe_ctrl
//
// Sequencing controller for the MDU's 3-stage multiplier datapath:
//   S1 Booth partial-product generation
//   S2 carry-save compression tree
//   S3 final carry-propagate add and high/low select
// The block tracks valid/op/tag for each stage. It turns the issue and response
// valid/ready handshakes into per-stage load enables, and it kills in-flight
// work on flush. It contains no arithmetic.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          kill all in-flight operations
//   req_valid_i      issue request valid
//   req_ready_o      controller accepts a request this cycle
//   req_op_i         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_tag_i        request tag (destination / ROB id)
//   s1_en_o          load S1 datapath registers
//   s2_en_o          load S2 datapath registers
//   s3_en_o          load S3 result register
//   s1_sign_a_o      operand A is signed (Booth encoding)
//   s1_sign_b_o      operand B is signed
//   s3_sel_hi_o      S3 takes product bits [63:32], sampled with s3_en_o
//   rsp_valid_o      result valid in S3
//   rsp_ready_i      consumer accepts the result
//   rsp_op_o         op of the S3 entry
//   rsp_tag_o        tag of the S3 entry
//   busy_o           any stage holds a valid operation
// -----------------------------------------------------------------------------
module mul_pipe_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             s1_en_o,
    output logic             s2_en_o,
    output logic             s3_en_o,
    output logic             s1_sign_a_o,
    output logic             s1_sign_b_o,
    output logic             s3_sel_hi_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_op_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // Per-stage tracking state
    logic             v1, v2, v3;
    logic [1:0]       op1, op2, op3;
    logic [TAG_W-1:0] tag1, tag2, tag3;

    logic adv1, adv2, adv3;
    logic accept;

    // A stage may advance when it is empty or the stage after it advances.
    // An empty stage therefore always advances, so bubbles collapse even
    // while S3 is stalled.
    assign adv3   = !v3 | rsp_ready_i;
    assign adv2   = !v2 | adv3;
    assign adv1   = !v1 | adv2;

    assign req_ready_o = adv1 & !flush_i;
    assign accept      = req_valid_i & req_ready_o;

    // Enables fire only when valid data moves into a stage, so idle datapath
    // registers are not clocked.
    assign s1_en_o = accept;
    assign s2_en_o = v1 & adv2;
    assign s3_en_o = v2 & adv3;

    assign s1_sign_a_o = (req_op_i == OP_MULH) | (req_op_i == OP_MULHSU);
    assign s1_sign_b_o = (req_op_i == OP_MULH);

    // Decided from the op that is about to enter S3.
    assign s3_sel_hi_o = (op2 != OP_MUL);

    // A flushed result must never complete a handshake.
    assign rsp_valid_o = v3 & !flush_i;
    assign rsp_op_o    = op3;
    assign rsp_tag_o   = tag3;

    assign busy_o = v1 | v2 | v3;

    // NOTE: every state register uses non-blocking assignment. Each stage
    // therefore reads its upstream neighbour's pre-edge value, and the three
    // updates below can be written in any order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            op1  <= '0;
            op2  <= '0;
            op3  <= '0;
            tag1 <= '0;
            tag2 <= '0;
            tag3 <= '0;
        end else if (flush_i) begin
            // Clearing the valid bits is enough. Stale ops and tags are
            // never observed without a valid bit.
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv3) begin
                v3   <= v2;
                op3  <= op2;
                tag3 <= tag2;
            end
            if (adv2) begin
                v2   <= v1;
                op2  <= op1;
                tag2 <= tag1;
            end
            if (adv1) begin
                v1   <= accept;
                op1  <= req_op_i;
                tag1 <= req_tag_i;
            end
        end
    end

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_pipe_ctrl
//
// Self-checking bench for mul_pipe_ctrl. The reference model is an ordered
// queue of in-flight operations, each annotated with the stage it occupies.
// On every cycle the oldest entry leaves from stage 3 when the consumer is
// ready. Each younger entry then moves one stage forward if the stage ahead
// is free. A new request joins at stage 1. A flush empties the queue.
// -----------------------------------------------------------------------------
module tb_mul_pipe_ctrl;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_op_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             s1_en_o, s2_en_o, s3_en_o;
    logic             s1_sign_a_o, s1_sign_b_o, s3_sel_hi_o;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [1:0]       rsp_op_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             busy_o;

    mul_pipe_ctrl #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_tag_i   (req_tag_i),
        .s1_en_o     (s1_en_o),
        .s2_en_o     (s2_en_o),
        .s3_en_o     (s3_en_o),
        .s1_sign_a_o (s1_sign_a_o),
        .s1_sign_b_o (s1_sign_b_o),
        .s3_sel_hi_o (s3_sel_hi_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_op_o    (rsp_op_o),
        .rsp_tag_o   (rsp_tag_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        int               stage;
    } ent_t;

    typedef struct {
        logic             ready;
        logic             rsp_valid;
        logic [1:0]       rsp_op;
        logic [TAG_W-1:0] rsp_tag;
        logic             s1, s2, s3;
        logic             sa, sb, hi;
        logic             busy;
    } obs_t;

    typedef struct {
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic             sa;
        logic             sb;
        logic             hi;
    } vec_t;

    ent_t q[$];
    int   got[$];
    int   got_cyc[$];
    int   cyc;
    int   n_cmp;
    int   n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model at the clock edge.
    task automatic step(input logic rv, input logic [1:0] op, input logic [TAG_W-1:0] tg,
                        input logic rr, input logic fl, output obs_t o);
        ent_t nq[$];
        ent_t e;
        logic e_ready, e_rv, e_s2, e_s3, e_hi;
        int   lim;
        @(negedge clk);
        req_valid_i = rv;
        req_op_i    = op;
        req_tag_i   = tg;
        rsp_ready_i = rr;
        flush_i     = fl;
        #1;
        o.ready     = req_ready_o;
        o.rsp_valid = rsp_valid_o;
        o.rsp_op    = rsp_op_o;
        o.rsp_tag   = rsp_tag_o;
        o.s1        = s1_en_o;
        o.s2        = s2_en_o;
        o.s3        = s3_en_o;
        o.sa        = s1_sign_a_o;
        o.sb        = s1_sign_b_o;
        o.hi        = s3_sel_hi_o;
        o.busy      = busy_o;

        // Only a full pipeline that cannot drain blocks a new request.
        e_ready = !fl && !(q.size() == 3 && !rr);
        e_rv    = (q.size() > 0) && (q[0].stage == 3) && !fl;
        nq = q;
        if (nq.size() > 0 && nq[0].stage == 3 && rr) void'(nq.pop_front());
        e_s2 = 1'b0;
        e_s3 = 1'b0;
        e_hi = 1'b0;
        for (int i = 0; i < nq.size(); i++) begin
            lim = (i == 0) ? 3 : nq[i-1].stage - 1;
            if (nq[i].stage < lim) begin
                if (nq[i].stage == 2) begin
                    e_s3 = 1'b1;
                    e_hi = (nq[i].op != 2'b00);
                end
                if (nq[i].stage == 1) e_s2 = 1'b1;
                e = nq[i];
                e.stage = e.stage + 1;
                nq[i] = e;
            end
        end
        if (rv && e_ready) nq.push_back('{op: op, tag: tg, stage: 1});
        if (fl) nq.delete();

        check("req_ready", o.ready, e_ready);
        check("rsp_valid", o.rsp_valid, e_rv);
        check("busy", o.busy, q.size() > 0);
        check("s1_en", o.s1, rv && e_ready);
        check("s2_en", o.s2, e_s2);
        check("s3_en", o.s3, e_s3);
        check("sign_a", o.sa, (op == 2'b01) || (op == 2'b10));
        check("sign_b", o.sb, op == 2'b01);
        if (e_rv) begin
            check("rsp_tag", o.rsp_tag, q[0].tag);
            check("rsp_op", o.rsp_op, q[0].op);
        end
        if (e_s3) check("sel_hi", o.hi, e_hi);
        if (o.rsp_valid && rr) begin
            got.push_back(int'(o.rsp_tag));
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        q = nq;
        cyc++;
    endtask

    task automatic idle(input logic rr, input int n);
        obs_t o;
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, rr, 1'b0, o);
    endtask

    // Issue one op into an empty pipeline. Check the sign decode on accept,
    // the S3 load with its high/low select, and the 3-cycle latency.
    task automatic single(input vec_t v);
        obs_t o;
        int   seen;
        step(1'b1, v.op, v.tag, 1'b1, 1'b0, o);
        check("issue_ready", o.ready, 1);
        check("issue_sign_a", o.sa, v.sa);
        check("issue_sign_b", o.sb, v.sb);
        seen = -1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 2'b00, '0, 1'b1, 1'b0, o);
            if (k == 1) begin
                check("s3_load", o.s3, 1);
                check("s3_load_hi", o.hi, v.hi);
            end
            if (o.rsp_valid && seen < 0) begin
                seen = k;
                check("single_tag", o.rsp_tag, v.tag);
                check("single_op", o.rsp_op, v.op);
            end
        end
        check("latency", seen, 2);
    endtask

    vec_t       vecs[5];
    logic [1:0] b2b_ops[4];

    initial begin
        obs_t o;
        logic rv, rr, fl;
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;

        // Expected sign/select values come from the op truth table.
        vecs[0] = '{op: 2'b10, tag: 5'd7,  sa: 1'b1, sb: 1'b0, hi: 1'b1};  // MULHSU
        vecs[1] = '{op: 2'b00, tag: 5'd3,  sa: 1'b0, sb: 1'b0, hi: 1'b0};  // MUL
        vecs[2] = '{op: 2'b01, tag: 5'd12, sa: 1'b1, sb: 1'b1, hi: 1'b1};  // MULH
        vecs[3] = '{op: 2'b11, tag: 5'd31, sa: 1'b0, sb: 1'b0, hi: 1'b1};  // MULHU
        vecs[4] = '{op: 2'b00, tag: 5'd0,  sa: 1'b0, sb: 1'b0, hi: 1'b0};  // MUL
        b2b_ops[0] = 2'b00;
        b2b_ops[1] = 2'b01;
        b2b_ops[2] = 2'b11;
        b2b_ops[3] = 2'b00;

        // Reset state, checked while reset is held and across a clock edge.
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        req_op_i    = 2'b00;
        req_tag_i   = '0;
        rsp_ready_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            #3;
            check("rst_ready", req_ready_o, 1);
            check("rst_rsp_valid", rsp_valid_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_en", {s1_en_o, s2_en_o, s3_en_o}, 0);
            check("rst_rsp_tag", rsp_tag_o, 0);
            check("rst_rsp_op", rsp_op_o, 0);
            #2;
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single operations
        foreach (vecs[i]) single(vecs[i]);

        // Back-to-back issue with the consumer always ready
        got.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, b2b_ops[i], TAG_W'(i + 1), 1'b1, 1'b0, o);
            check("b2b_ready", o.ready, 1);
        end
        idle(1'b1, 5);
        check("b2b_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check("b2b_order", got[i], i + 1);
        if (got_cyc.size() == 4) check("b2b_consecutive", got_cyc[3] - got_cyc[0], 3);

        // Backpressure: three ops are buffered, then issue stalls
        got.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b11, TAG_W'(i + 1), 1'b0, 1'b0, o);
            check("bp_ready", o.ready, i < 3);
        end
        step(1'b1, 2'b11, 5'd4, 1'b1, 1'b0, o);
        check("bp_reissue4", o.ready, 1);
        step(1'b1, 2'b11, 5'd5, 1'b1, 1'b0, o);
        check("bp_reissue5", o.ready, 1);
        idle(1'b1, 6);
        check("bp_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) check("bp_order", got[i], i + 1);

        // Flush a full pipeline, with a coincident request and a ready consumer
        got.delete();
        for (int i = 4; i <= 6; i++) step(1'b1, 2'b01, TAG_W'(i), 1'b0, 1'b0, o);
        step(1'b1, 2'b00, 5'd10, 1'b1, 1'b1, o);
        check("flush_ready", o.ready, 0);
        check("flush_rsp_valid", o.rsp_valid, 0);
        step(1'b1, 2'b00, 5'd11, 1'b1, 1'b1, o);
        check("flush_busy", o.busy, 0);
        check("flush2_ready", o.ready, 0);
        step(1'b0, 2'b00, '0, 1'b1, 1'b0, o);
        check("flush2_busy", o.busy, 0);
        idle(1'b1, 4);
        check("flush_none_delivered", got.size(), 0);

        // Asynchronous reset in the middle of an operation
        step(1'b1, 2'b00, 5'd9, 1'b1, 1'b0, o);
        step(1'b0, 2'b00, '0, 1'b1, 1'b0, o);
        check("pre_rst_busy", busy_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy_o, 0);
        check("async_rst_rsp_valid", rsp_valid_o, 0);
        check("async_rst_ready", req_ready_o, 1);
        q.delete();
        #4 rst_n = 1'b1;
        single('{op: 2'b01, tag: 5'd11, sa: 1'b1, sb: 1'b1, hi: 1'b1});

        // Bubble collapse behind a stalled S3
        got.delete();
        step(1'b1, 2'b00, 5'd1, 1'b0, 1'b0, o);
        idle(1'b0, 2);
        step(1'b1, 2'b11, 5'd2, 1'b0, 1'b0, o);
        check("bubble_ready", o.ready, 1);
        step(1'b0, 2'b00, '0, 1'b0, 1'b0, o);
        check("bubble_s2_en", o.s2, 1);
        check("bubble_s3_tag", o.rsp_tag, 1);
        check("bubble_ready2", o.ready, 1);
        step(1'b0, 2'b00, '0, 1'b0, 1'b0, o);
        check("bubble_s3_hold", o.s3, 0);
        idle(1'b1, 4);
        check("bubble_count", got.size(), 2);
        if (got.size() == 2) begin
            check("bubble_first", got[0], 1);
            check("bubble_second", got[1], 2);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            step(rv, 2'($urandom_range(0, 3)), TAG_W'($urandom), rr, fl, o);
        end
        idle(1'b1, 5);
        check("final_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
